// File: rtl/wishbone_to_axi4_master.sv
// Wishbone classic slave to single-beat AXI4 master bridge.
// It keeps one transaction in flight. It issues no bursts. An AXI
// SLVERR or DECERR response is returned to the Wishbone side as WB_ERR.
module wishbone_to_axi4_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int AXI_ID     = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // Wishbone slave port
  input  logic                    WB_CYC,
  input  logic                    WB_STB,
  input  logic                    WB_WE,
  input  logic [ADDR_WIDTH-1:0]   WB_ADDR,
  input  logic [DATA_WIDTH-1:0]   WB_WDATA,
  input  logic [DATA_WIDTH/8-1:0] WB_SEL,
  output logic [DATA_WIDTH-1:0]   WB_RDATA,
  output logic                    WB_ACK,
  output logic                    WB_ERR,
  // AXI4 write address channel
  output logic [ID_WIDTH-1:0]     M_AXI_AWID,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]              M_AXI_AWLEN,
  output logic [2:0]              M_AXI_AWSIZE,
  output logic [1:0]              M_AXI_AWBURST,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  // AXI4 write data channel
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WLAST,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  // AXI4 write response channel
  input  logic [ID_WIDTH-1:0]     M_AXI_BID,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  // AXI4 read address channel
  output logic [ID_WIDTH-1:0]     M_AXI_ARID,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]              M_AXI_ARLEN,
  output logic [2:0]              M_AXI_ARSIZE,
  output logic [1:0]              M_AXI_ARBURST,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  // AXI4 read data channel
  input  logic [ID_WIDTH-1:0]     M_AXI_RID,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RLAST,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched request
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_sel;

  // Registered AXI handshake outputs and write-channel completion flags
  logic r_awvalid, r_wvalid, r_arvalid, r_bready, r_rready;
  logic r_aw_done, r_w_done;
  logic w_awvalid_nxt, w_wvalid_nxt, w_arvalid_nxt, w_bready_nxt, w_rready_nxt;
  logic w_aw_flag_nxt, w_w_flag_nxt;

  // Response bookkeeping
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic w_req, w_aw_fire, w_w_fire, w_aw_done_nxt, w_w_done_nxt;
  logic w_unused;

  assign w_req         = WB_CYC & WB_STB;
  assign w_aw_fire     = r_awvalid & M_AXI_AWREADY;
  assign w_w_fire      = r_wvalid  & M_AXI_WREADY;
  assign w_aw_done_nxt = r_aw_done | w_aw_fire;
  assign w_w_done_nxt  = r_w_done  | w_w_fire;

  // Response IDs and RLAST carry no information for single-beat, single-ID traffic
  assign w_unused = ^{M_AXI_BID, M_AXI_RID, M_AXI_RLAST};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so no path through the case leaves a variable unassigned (no latch).
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_req) w_state_nxt = WB_WE ? S_WRITE : S_RD_ADDR;
      S_WRITE:   if (w_aw_done_nxt && w_w_done_nxt) w_state_nxt = S_WR_RESP;
      S_WR_RESP: if (M_AXI_BVALID) w_state_nxt = S_DONE;
      S_RD_ADDR: if (M_AXI_ARREADY) w_state_nxt = S_RD_DATA;
      S_RD_DATA: if (M_AXI_RVALID) w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered AXI handshakes, derived from the next state
  always_comb begin
    w_aw_flag_nxt = 1'b0;
    w_w_flag_nxt  = 1'b0;
    if (r_state == S_WRITE) begin
      w_aw_flag_nxt = w_aw_done_nxt;
      w_w_flag_nxt  = w_w_done_nxt;
    end
    w_awvalid_nxt = (w_state_nxt == S_WRITE) && !w_aw_flag_nxt;
    w_wvalid_nxt  = (w_state_nxt == S_WRITE) && !w_w_flag_nxt;
    w_arvalid_nxt = (w_state_nxt == S_RD_ADDR);
    w_bready_nxt  = (w_state_nxt == S_WR_RESP);
    w_rready_nxt  = (w_state_nxt == S_RD_DATA);
  end

  // Handshake output registers; reset drops every VALID/READY at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
      r_bready  <= 1'b0;
      r_rready  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_awvalid <= w_awvalid_nxt;
      r_wvalid  <= w_wvalid_nxt;
      r_arvalid <= w_arvalid_nxt;
      r_bready  <= w_bready_nxt;
      r_rready  <= w_rready_nxt;
      r_aw_done <= w_aw_flag_nxt;
      r_w_done  <= w_w_flag_nxt;
    end
  end

  // Request capture; only an idle bridge accepts a new strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_sel   <= '0;
    end else if (r_state == S_IDLE && w_req) begin
      r_addr  <= WB_ADDR;
      r_wdata <= WB_WDATA;
      r_sel   <= WB_SEL;
    end
  end

  // Response capture; read data survives until the next read completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else if (r_state == S_WR_RESP && M_AXI_BVALID) begin
      r_err   <= (M_AXI_BRESP != 2'b00);
    end else if (r_state == S_RD_DATA && M_AXI_RVALID) begin
      r_err   <= (M_AXI_RRESP != 2'b00);
      r_rdata <= M_AXI_RDATA;
    end
  end

  // Wishbone completion: one-cycle pulse in DONE, withheld if the master abandoned the cycle
  assign WB_ACK   = (r_state == S_DONE) && WB_CYC && !r_err;
  assign WB_ERR   = (r_state == S_DONE) && WB_CYC &&  r_err;
  assign WB_RDATA = r_rdata;

  assign M_AXI_AWID    = ID_WIDTH'(AXI_ID);
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWLEN   = 8'd0;
  assign M_AXI_AWSIZE  = 3'b010;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWVALID = r_awvalid;

  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_sel;
  assign M_AXI_WLAST   = 1'b1;
  assign M_AXI_WVALID  = r_wvalid;

  assign M_AXI_BREADY  = r_bready;

  assign M_AXI_ARID    = ID_WIDTH'(AXI_ID);
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_ARSIZE  = 3'b010;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARVALID = r_arvalid;

  assign M_AXI_RREADY  = r_rready;

endmodule
